// File: rtl/rtc_pkg.sv
// rtc_pkg: phase constants, register address table, FSM encoding and BCD helper for the RTC read sequencer
package rtc_pkg;
  localparam int NUM_REGS = 6;
  localparam int TXN_LEN = 10;
  localparam logic [3:0] P_ADDR_LO = 4'd0;
  localparam logic [3:0] P_ADDR_HI = 4'd3;
  localparam logic [3:0] P_WR_LO = 4'd1;
  localparam logic [3:0] P_WR_HI = 4'd2;
  localparam logic [3:0] P_TURN = 4'd4;
  localparam logic [3:0] P_RD_LO = 4'd5;
  localparam logic [3:0] P_RD_HI = 4'd8;
  localparam logic [3:0] P_CAPT = 4'd7;
  localparam logic [3:0] P_LAST = 4'(TXN_LEN - 1);
  localparam logic [7:0] ADDR [0:NUM_REGS-1] = '{8'h00, 8'h02, 8'h04, 8'h07, 8'h08, 8'h09};
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  function automatic logic in_rng(input logic [3:0] p, input logic [3:0] lo, input logic [3:0] hi);
    return p >= lo && p <= hi;
  endfunction
  function automatic logic bad_bcd(input logic [8*NUM_REGS-1:0] d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 2 * NUM_REGS; i++) bad = bad | (d[4*i +: 4] > 4'h9);
    return bad;
  endfunction
endpackage

// File: rtl/rtc_bus_phase_gen.sv
// rtc_bus_phase_gen: per-transaction phase counter with registered RTC bus strobe decode
module rtc_bus_phase_gen
  import rtc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run_i,
  input  logic       clear_i,
  input  logic [7:0] addr_i,
  output logic [3:0] p_o,
  output logic       last_o,
  output logic       cs_n_o,
  output logic       rd_n_o,
  output logic       wr_n_o,
  output logic       a_d_o,
  output logic       bus_oe_o,
  output logic [7:0] bus_out_o
);
  logic       act_q, act_d, addr_ph, wr_ph, rd_ph;
  logic [3:0] p_q, p_d;
  logic       cs_n_q, rd_n_q, wr_n_q, a_d_q, oe_q;
  logic [7:0] bus_out_q;
  // strobes are decoded from the next phase so they are registered yet aligned with p
  always_comb begin
    act_d = run_i & ~clear_i;
    p_d = (act_d && act_q && p_q != P_LAST) ? p_q + 4'd1 : 4'd0;
    addr_ph = act_d && in_rng(p_d, P_ADDR_LO, P_ADDR_HI);
    wr_ph = act_d && in_rng(p_d, P_WR_LO, P_WR_HI);
    rd_ph = act_d && in_rng(p_d, P_RD_LO, P_RD_HI);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      act_q <= 1'b0;
      p_q <= 4'd0;
      cs_n_q <= 1'b1;
      rd_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      a_d_q <= 1'b1;
      oe_q <= 1'b0;
      bus_out_q <= 8'h00;
    end else begin
      act_q <= act_d;
      p_q <= p_d;
      cs_n_q <= ~(wr_ph | rd_ph);
      rd_n_q <= ~rd_ph;
      wr_n_q <= ~wr_ph;
      a_d_q <= ~addr_ph;
      oe_q <= addr_ph;
      bus_out_q <= addr_ph ? addr_i : 8'h00;
    end
  assign p_o = p_q;
  assign last_o = act_q && p_q == P_LAST;
  assign cs_n_o = cs_n_q;
  assign rd_n_o = rd_n_q;
  assign wr_n_o = wr_n_q;
  assign a_d_o = a_d_q;
  assign bus_oe_o = oe_q;
  assign bus_out_o = bus_out_q;
endmodule

// File: rtl/rtc_read_sequencer.sv
// rtc_read_sequencer: reads the RTC time/date registers into a shadow buffer and commits the frame atomically
module rtc_read_sequencer
  import rtc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            bus_in,
  output logic [7:0]            bus_out,
  output logic                  bus_oe,
  output logic                  cs_n,
  output logic                  rd_n,
  output logic                  wr_n,
  output logic                  a_d,
  output logic                  busy,
  output logic                  done,
  output logic [8*NUM_REGS-1:0] data_out,
  output logic                  bcd_err
);
  state_e                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [3:0]            p;
  logic                  last;
  logic [8*NUM_REGS-1:0] shadow_q, data_q;
  logic                  busy_q, done_q, bcd_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    case (state_q)
      S_IDLE: if (start && !abort) begin
        state_d = S_RUN;
        idx_d = 3'd0;
      end
      S_RUN: if (abort) state_d = S_IDLE;
        else if (last) begin
          if (idx_q == 3'(NUM_REGS - 1)) state_d = S_DONE;
          else idx_d = idx_q + 3'd1;
        end
      default: state_d = S_IDLE;
    endcase
  end
  rtc_bus_phase_gen u_phase (
    .clk       (clk),
    .reset_n   (reset_n),
    .run_i     (state_d == S_RUN),
    .clear_i   (abort),
    .addr_i    (ADDR[idx_d]),
    .p_o       (p),
    .last_o    (last),
    .cs_n_o    (cs_n),
    .rd_n_o    (rd_n),
    .wr_n_o    (wr_n),
    .a_d_o     (a_d),
    .bus_oe_o  (bus_oe),
    .bus_out_o (bus_out)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q <= 3'd0;
      shadow_q <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      busy_q <= state_d != S_IDLE;
      done_q <= state_d == S_DONE;
      if (state_q == S_RUN && p == P_CAPT) shadow_q[{idx_q, 3'b000} +: 8] <= bus_in;
      if (state_q == S_RUN && state_d == S_DONE) begin
        data_q <= shadow_q;
        bcd_q <= bad_bcd(shadow_q);
      end
    end
  assign busy = busy_q;
  assign done = done_q;
  assign data_out = data_q;
  assign bcd_err = bcd_q;
endmodule
